// File: rtl/posit_pkg.sv
// Shared posit definitions: scale width, saturation limits, special encodings
// and the decoded-field bundle exchanged between posit encoder and decoder.
package posit_pkg;

  localparam int SCALE_W  = 8;
  localparam int FRAC_MAX = 32;
  localparam int WORD_MAX = 32;

  typedef logic [WORD_MAX-1:0]       posit_word_t;
  typedef logic [FRAC_MAX-1:0]       posit_frac_t;
  typedef logic signed [SCALE_W-1:0] posit_scale_t;

  // Fraction is left-justified in FRAC_MAX bits: MSB weighs 2^-1.
  typedef struct packed {
    logic         sign;
    logic         zero;
    logic         nar;
    posit_scale_t scale;
    posit_frac_t  fraction;
    logic         sticky;
  } posit_fields_t;

  function automatic int posit_maxscale(input int width, input int es);
    return (width - 2) * (1 << es);
  endfunction

  function automatic posit_word_t posit_maxpos(input int width);
    return (posit_word_t'(1) << (width - 1)) - posit_word_t'(1);
  endfunction

  function automatic posit_word_t posit_minpos();
    return posit_word_t'(1);
  endfunction

  function automatic posit_word_t posit_nar(input int width);
    return posit_word_t'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/posit_regime_pack.sv
// Combinational regime/exponent/fraction packer: builds the unrounded posit
// magnitude plus guard and sticky bits, with scale saturation to maxpos/minpos.
module posit_regime_pack
  import posit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ES    = 2
) (
  input  logic signed [SCALE_W-1:0] i_scale,
  input  logic [FRAC_MAX-1:0]       i_fraction,
  input  logic                      i_sticky,
  output logic [WIDTH-2:0]          o_mag,
  output logic                      o_guard,
  output logic                      o_sticky,
  output logic                      o_sat
);

  localparam int EF_W     = ES + FRAC_MAX;
  localparam int VW       = 2 + EF_W + WIDTH;
  localparam int MAXSCALE = posit_maxscale(WIDTH, ES);
  localparam logic [WIDTH-2:0] MAG_MAX = (WIDTH-1)'(posit_maxpos(WIDTH));
  localparam logic [WIDTH-2:0] MAG_MIN = (WIDTH-1)'(posit_minpos());

  logic signed [SCALE_W-1:0] w_k;
  logic                      w_neg;
  logic [SCALE_W-1:0]        w_sh;
  logic [EF_W-1:0]           w_ef;
  logic [VW-1:0]             w_vec;
  logic [VW-1:0]             w_shifted;
  logic [WIDTH-2:0]          w_mag_raw;
  logic                      w_guard;
  logic                      w_rest;
  logic                      w_sat_hi;
  logic                      w_sat_lo;

  function automatic logic [WIDTH-2:0] sat_mag(input logic hi, input logic lo,
                                               input logic [WIDTH-2:0] raw);
    if (hi) return MAG_MAX;
    if (lo) return MAG_MIN;
    return raw;
  endfunction

  assign w_k   = i_scale >>> ES;
  assign w_neg = w_k[SCALE_W-1];
  // -k-1 == ~k, so one shifter serves both regime polarities
  assign w_sh  = w_neg ? ~w_k : w_k;

  generate
    if (ES == 0) begin : g_no_exp
      assign w_ef = i_fraction;
    end else begin : g_exp
      assign w_ef = {i_scale[ES-1:0], i_fraction};
    end
  endgenerate

  // Seed "10" (k>=0) or "01" (k<0); the arithmetic shift replicates the
  // leading regime bit, and the zero tail keeps every shifted-out bit.
  assign w_vec     = {~w_neg, w_neg, w_ef, {WIDTH{1'b0}}};
  assign w_shifted = $signed(w_vec) >>> w_sh;

  assign w_mag_raw = w_shifted[VW-1 -: WIDTH-1];
  assign w_guard   = w_shifted[VW-WIDTH];
  assign w_rest    = |w_shifted[VW-WIDTH-1:0];

  assign w_sat_hi = int'(i_scale) > MAXSCALE;
  assign w_sat_lo = int'(i_scale) < -MAXSCALE;

  // Saturated results report inexact via sticky but never round further.
  always_comb begin
    o_sat    = w_sat_hi | w_sat_lo;
    o_mag    = sat_mag(w_sat_hi, w_sat_lo, w_mag_raw);
    o_guard  = o_sat ? 1'b0 : w_guard;
    o_sticky = o_sat ? 1'b1 : (w_rest | i_sticky);
  end

endmodule

// File: rtl/posit_encoder_pipe.sv
// Two-stage valid/ready posit encoder: regime packing, then round-to-nearest-
// even, clamping and sign application, with per-stage bubble collapse.
module posit_encoder_pipe
  import posit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ES      = 2,
  parameter int FRAC_IN = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sign,
  input  logic                      in_zero,
  input  logic                      in_nar,
  input  logic signed [SCALE_W-1:0] in_scale,
  input  logic [FRAC_IN-1:0]        in_fraction,
  input  logic                      in_sticky,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_posit,
  output logic                      out_inexact,
  output logic                      out_sat
);

  localparam logic [WIDTH-2:0] MAG_MAX  = (WIDTH-1)'(posit_maxpos(WIDTH));
  localparam logic [WIDTH-2:0] MAG_MIN  = (WIDTH-1)'(posit_minpos());
  localparam logic [WIDTH-1:0] NAR_WORD = WIDTH'(posit_nar(WIDTH));

  posit_fields_t    w_fields;
  logic             w_load_p1;
  logic             w_load_p2;
  logic [WIDTH-2:0] w_mag;
  logic             w_guard;
  logic             w_sticky;
  logic             w_sat;
  logic [WIDTH-1:0] w_posit_d;
  logic             w_inexact_d;
  logic             w_sat_d;

  logic             r_vld_p1;
  logic [WIDTH-2:0] r_mag_p1;
  logic             r_guard_p1;
  logic             r_sticky_p1;
  logic             r_sat_p1;
  logic             r_sign_p1;
  logic             r_zero_p1;
  logic             r_nar_p1;

  logic             r_vld_p2;
  logic [WIDTH-1:0] r_posit_p2;
  logic             r_inexact_p2;
  logic             r_sat_p2;

  function automatic logic [WIDTH-2:0] clamp_mag(input logic [WIDTH-1:0] sum);
    if (sum[WIDTH-1]) return MAG_MAX;
    if (sum[WIDTH-2:0] == '0) return MAG_MIN;
    return sum[WIDTH-2:0];
  endfunction

  function automatic logic [WIDTH-2:0] round_rne(input logic [WIDTH-2:0] mag,
                                                 input logic guard,
                                                 input logic sticky);
    logic inc;
    inc = guard & (sticky | mag[0]);
    return clamp_mag({1'b0, mag} + {{(WIDTH-1){1'b0}}, inc});
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic sign,
                                                  input logic [WIDTH-2:0] mag);
    logic [WIDTH-1:0] word;
    word = {1'b0, mag};
    return sign ? (~word + WIDTH'(1)) : word;
  endfunction

  always_comb begin
    w_fields          = '0;
    w_fields.sign     = in_sign;
    w_fields.zero     = in_zero;
    w_fields.nar      = in_nar;
    w_fields.scale    = in_scale;
    w_fields.fraction = posit_frac_t'(in_fraction) << (FRAC_MAX - FRAC_IN);
    w_fields.sticky   = in_sticky;
  end

  assign w_load_p2 = ~r_vld_p2 | out_ready;
  assign w_load_p1 = ~r_vld_p1 | w_load_p2;
  assign in_ready  = w_load_p1;

  posit_regime_pack #(
    .WIDTH (WIDTH),
    .ES    (ES)
  ) u_pack (
    .i_scale    (w_fields.scale),
    .i_fraction (w_fields.fraction),
    .i_sticky   (w_fields.sticky),
    .o_mag      (w_mag),
    .o_guard    (w_guard),
    .o_sticky   (w_sticky),
    .o_sat      (w_sat)
  );

  // ---- stage 1: unrounded magnitude, guard/sticky, special flags ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
    end else if (w_load_p1) begin
      r_vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (w_load_p1 && in_valid) begin
      r_mag_p1    <= w_mag;
      r_guard_p1  <= w_guard;
      r_sticky_p1 <= w_sticky;
      r_sat_p1    <= w_sat;
      r_sign_p1   <= w_fields.sign;
      r_zero_p1   <= w_fields.zero;
      r_nar_p1    <= w_fields.nar;
    end
  end

  // ---- stage 2: rounding, sign, specials ----
  always_comb begin
    w_posit_d   = apply_sign(r_sign_p1, round_rne(r_mag_p1, r_guard_p1, r_sticky_p1));
    w_inexact_d = r_guard_p1 | r_sticky_p1;
    w_sat_d     = r_sat_p1;
    if (r_nar_p1) begin
      w_posit_d   = NAR_WORD;
      w_inexact_d = 1'b0;
      w_sat_d     = 1'b0;
    end else if (r_zero_p1) begin
      w_posit_d   = '0;
      w_inexact_d = 1'b0;
      w_sat_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p2     <= 1'b0;
      r_posit_p2   <= '0;
      r_inexact_p2 <= 1'b0;
      r_sat_p2     <= 1'b0;
    end else if (w_load_p2) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_posit_p2   <= w_posit_d;
        r_inexact_p2 <= w_inexact_d;
        r_sat_p2     <= w_sat_d;
      end
    end
  end

  assign out_valid   = r_vld_p2;
  assign out_posit   = r_posit_p2;
  assign out_inexact = r_inexact_p2;
  assign out_sat     = r_sat_p2;

endmodule
